control_multiciclo: RTL

Multi-cycle control unit that sequences the processor datapath instantiated in `main`. It runs fetch, decode, execute, memory and write-back for a 16-bit instruction whose opcode is in bits [15:12]. It emits one-hot-style strobes (PC/IR/register-file write enables, ALU select, mux selects) and drives a req/ack handshake to the shared instruction/data memory. It also keeps a retired-instruction counter for observing the datapath `resultado` under test.

---
 rtl/control_multiciclo_if.sv | 19 +
 rtl/control_multiciclo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/control_multiciclo_if.sv
// Memory handshake bundle between control_multiciclo and the shared
// instruction/data memory: request, write select and completion ack.
interface control_multiciclo_if;
  logic mem_req;
  logic mem_we;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ack
  );
endinterface

// File: rtl/control_multiciclo.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing for a
// 16-bit instruction (opcode in IR[15:12]), memory req/ack handshake and
// a retired-instruction counter.
// Optional feature macro: ILLEGAL_TRAP_EN (undefined opcodes trap to HALT
// and set the sticky illegal flag; otherwise they retire as NOP).
module control_multiciclo #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  control_multiciclo_if.master mem,
  input  logic [3:0]           opcode,
  input  logic                 zero,
  output logic                 addr_sel,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic [1:0]           alu_op,
  output logic                 alu_src_imm,
  output logic                 reg_we,
  output logic                 wb_sel,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_op;
  logic [3:0]       w_op;
  logic             w_retire;
  logic             r_mem_req;
  logic             r_mem_we;
  logic             r_addr_sel;
  logic [1:0]       r_pc_src;
  logic [1:0]       r_alu_op;
  logic             r_alu_src_imm;
  logic             r_reg_we;
  logic             r_wb_sel;
  logic             r_halted;
  logic [CNT_W-1:0] r_instr_count;
`ifdef ILLEGAL_TRAP_EN
  logic             w_trap;
  logic             r_illegal;
`endif

  // Next-state decode; the opcode is taken live in DECODE, latched after.
  always_comb begin
    w_op   = (r_state == S_DECODE) ? opcode : r_op;
    w_next = r_state;
`ifdef ILLEGAL_TRAP_EN
    w_trap = 1'b0;
`endif
    case (r_state)
      S_START:  w_next = S_FETCH;
      S_FETCH:  if (mem.mem_ack) w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_HALT: w_next = S_HALT;
          OP_NOP:  w_next = S_FETCH;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
          OP_LD, OP_ST, OP_BEQ, OP_JMP: w_next = S_EXEC;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            w_next = S_HALT;
            w_trap = 1'b1;
`else
            w_next = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC: begin
        case (w_op)
          OP_LD, OP_ST:   w_next = S_MEM;
          OP_BEQ, OP_JMP: w_next = S_FETCH;
          default:        w_next = S_WB;
        endcase
      end
      S_MEM:    if (mem.mem_ack) w_next = (w_op == OP_LD) ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_START;
    endcase
    w_retire = (w_next == S_FETCH) &&
               (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB});
  end

  // State, latched opcode, counter and Moore outputs. Outputs are
  // registered from the state being entered so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_START;
      r_op          <= '0;
      r_instr_count <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_addr_sel    <= 1'b0;
      r_pc_src      <= '0;
      r_alu_op      <= '0;
      r_alu_src_imm <= 1'b0;
      r_reg_we      <= 1'b0;
      r_wb_sel      <= 1'b0;
      r_halted      <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      r_illegal     <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= opcode;
      if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
`ifdef ILLEGAL_TRAP_EN
      if (w_trap) r_illegal <= 1'b1;
`endif
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_addr_sel    <= 1'b0;
      r_pc_src      <= '0;
      r_alu_op      <= '0;
      r_alu_src_imm <= 1'b0;
      r_reg_we      <= 1'b0;
      r_wb_sel      <= 1'b0;
      r_halted      <= 1'b0;
      case (w_next)
        S_FETCH: r_mem_req <= 1'b1;
        S_EXEC: begin
          case (w_op)
            OP_SUB, OP_BEQ: r_alu_op <= 2'd1;
            OP_AND:         r_alu_op <= 2'd2;
            OP_OR:          r_alu_op <= 2'd3;
            default:        r_alu_op <= 2'd0;
          endcase
          r_alu_src_imm <= (w_op inside {OP_ADDI, OP_LD, OP_ST});
          if (w_op == OP_BEQ)      r_pc_src <= 2'd1;
          else if (w_op == OP_JMP) r_pc_src <= 2'd2;
        end
        S_MEM: begin
          r_mem_req  <= 1'b1;
          r_addr_sel <= 1'b1;
          r_mem_we   <= (w_op == OP_ST);
        end
        S_WB: begin
          r_reg_we <= 1'b1;
          r_wb_sel <= (w_op == OP_LD);
        end
        S_HALT:  r_halted <= 1'b1;
        default: ;
      endcase
    end
  end

  // Write strobes that depend on ack/zero in the current cycle; gated by
  // the registered state so reset removes them immediately.
  always_comb begin
    ir_we = (r_state == S_FETCH) && mem.mem_ack;
    pc_we = ir_we ||
            ((r_state == S_EXEC) &&
             ((r_op == OP_JMP) || ((r_op == OP_BEQ) && zero)));
  end

  assign mem.mem_req  = r_mem_req;
  assign mem.mem_we   = r_mem_we;
  assign addr_sel     = r_addr_sel;
  assign pc_src       = r_pc_src;
  assign alu_op       = r_alu_op;
  assign alu_src_imm  = r_alu_src_imm;
  assign reg_we       = r_reg_we;
  assign wb_sel       = r_wb_sel;
  assign halted       = r_halted;
  assign instr_count  = r_instr_count;
`ifdef ILLEGAL_TRAP_EN
  assign illegal      = r_illegal;
`else
  assign illegal      = 1'b0;
`endif

endmodule
